fp_share_arb: RTL and testbench

Round-robin scheduler sharing one fixed-latency pipelined FP unit (adder or multiplier, LAT cycles, no stall) among NREQ requesters. Accepts operand pairs over per-requester valid/ready, issues at most one operation per cycle, and carries the requester ID down a tag pipeline matched to the unit's latency. It steers each result back to its owner. Per-requester credit counters bound outstanding results so downstream result buffers never overflow. It sits between the matrix-vector lane controllers and the shared FP core.

---
 rtl/fp_share_arb.sv | 160 ++++++++++++++++
 tb/tb_fp_share_arb.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_share_arb.sv
// rtl/fp_share_arb.sv - round-robin scheduler sharing one fixed-latency pipelined FP unit
module fp_share_arb #(
    parameter int NREQ   = 4,
    parameter int LAT    = 12,
    parameter int DW     = 32,
    parameter int MAXOUT = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*DW-1:0] req_a,
    input  logic [NREQ*DW-1:0] req_b,
    output logic              fp_in_valid,
    output logic [DW-1:0]     fp_a,
    output logic [DW-1:0]     fp_b,
    input  logic              fp_r_valid,
    input  logic [DW-1:0]     fp_r,
    output logic [NREQ-1:0]   res_valid,
    output logic [DW-1:0]     res_data,
    input  logic [NREQ-1:0]   res_credit,
    output logic              err
);
    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW  = $clog2(MAXOUT + 1);
    localparam int WW  = $clog2(LAT + 2);
    localparam logic [CW-1:0] MAXC      = CW'(MAXOUT);
    localparam logic [WW-1:0] WARM_INIT = WW'(LAT + 1);

    logic [IDW-1:0] ptr;
    logic [CW-1:0]  cnt [NREQ];
    logic [NREQ-1:0] elig;
    logic           gnt_any;
    logic [IDW-1:0] gnt_id;
    logic [IDW-1:0] idx;
    logic [IDW-1:0] issue_id;
    logic [LAT-1:0] tag_v;
    logic [IDW-1:0] tag_id [LAT];
    logic [WW-1:0]  warm;
    logic           underflow;
    logic           tag_err;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            elig[i] = req_valid[i] && (cnt[i] < MAXC);
        end
    end

    // First eligible requester at or after ptr, wrapping.
    always_comb begin
        gnt_any   = 1'b0;
        gnt_id    = '0;
        idx       = '0;
        req_ready = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = IDW'((int'(ptr) + k) % NREQ);
            if (!gnt_any && elig[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
        if (gnt_any) begin
            req_ready[gnt_id] = 1'b1;
        end
    end

    always_comb begin
        underflow = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (res_credit[i] && !req_ready[i] && (cnt[i] == '0)) begin
                underflow = 1'b1;
            end
        end
    end

    assign tag_err = (warm == '0) && (fp_r_valid != tag_v[LAT-1]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr         <= '0;
            fp_in_valid <= 1'b0;
            fp_a        <= '0;
            fp_b        <= '0;
            issue_id    <= '0;
        end else begin
            fp_in_valid <= gnt_any;
            if (gnt_any) begin
                fp_a     <= req_a[gnt_id*DW +: DW];
                fp_b     <= req_b[gnt_id*DW +: DW];
                issue_id <= gnt_id;
                if (gnt_id == IDW'(NREQ - 1)) begin
                    ptr <= '0;
                end else begin
                    ptr <= gnt_id + 1'b1;
                end
            end
        end
    end

    // Requester ID travels alongside the FP unit so results can be steered home.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_v <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            tag_v[0]  <= fp_in_valid;
            tag_id[0] <= issue_id;
            for (int s = 1; s < LAT; s++) begin
                tag_v[s]  <= tag_v[s-1];
                tag_id[s] <= tag_id[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_valid <= '0;
            res_data  <= '0;
        end else begin
            res_valid <= '0;
            if (tag_v[LAT-1]) begin
                res_valid[tag_id[LAT-1]] <= 1'b1;
                res_data                 <= fp_r;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREQ; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREQ; i++) begin
                if (req_ready[i] && !res_credit[i]) begin
                    cnt[i] <= cnt[i] + 1'b1;
                end else if (!req_ready[i] && res_credit[i] && (cnt[i] != '0)) begin
                    cnt[i] <= cnt[i] - 1'b1;
                end
            end
        end
    end

    // Warm-up masks the tag check while an unreset FP pipeline drains.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm <= WARM_INIT;
            err  <= 1'b0;
        end else begin
            if (warm != '0) begin
                warm <= warm - 1'b1;
            end
            if (underflow || tag_err) begin
                err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_fp_share_arb.sv
// tb/tb_fp_share_arb.sv - self-checking bench for fp_share_arb
module tb_fp_share_arb;
    localparam int NREQ   = 4;
    localparam int LAT    = 12;
    localparam int DW     = 32;
    localparam int MAXOUT = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [NREQ-1:0]      req_valid = '0;
    logic [NREQ-1:0]      req_ready;
    logic [NREQ*DW-1:0]   req_a = '0;
    logic [NREQ*DW-1:0]   req_b = '0;
    logic                 fp_in_valid;
    logic [DW-1:0]        fp_a, fp_b;
    logic                 fp_r_valid;
    logic [DW-1:0]        fp_r;
    logic [NREQ-1:0]      res_valid;
    logic [DW-1:0]        res_data;
    logic [NREQ-1:0]      res_credit = '0;
    logic                 err;
    logic                 inject = 1'b0;

    fp_share_arb #(.NREQ(NREQ), .LAT(LAT), .DW(DW), .MAXOUT(MAXOUT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .fp_in_valid(fp_in_valid), .fp_a(fp_a),
        .fp_b(fp_b), .fp_r_valid(fp_r_valid), .fp_r(fp_r), .res_valid(res_valid),
        .res_data(res_data), .res_credit(res_credit), .err(err)
    );

    always #5 clk = ~clk;

    function automatic real f2r(input logic [31:0] a);
        logic [10:0] e;
        if (a[30:0] == 31'd0) return 0.0;
        e = {3'b000, a[30:23]} + 11'd896;
        return $bitstoreal({a[31], e, a[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fpadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] rnd_fp();
        return {1'($urandom_range(0, 1)), 8'($urandom_range(110, 140)), 23'($urandom)};
    endfunction

    // Non-reset FP adder model with LAT-cycle latency.
    logic [LAT-1:0] pv;
    logic [DW-1:0]  pd [LAT];
    always @(posedge clk) begin
        pv <= {pv[LAT-2:0], fp_in_valid};
        pd[0] <= fpadd(fp_a, fp_b);
        for (int s = 1; s < LAT; s++) pd[s] <= pd[s-1];
    end
    assign fp_r_valid = pv[LAT-1] | inject;
    assign fp_r       = pd[LAT-1];

    typedef struct { int id; logic [DW-1:0] d; int due; } exp_t;
    exp_t q[$];
    int mcnt [NREQ];
    int mptr, cyc, ksr, last_grant, n_res_seen;
    logic m_iv, m_err;
    logic [DW-1:0] m_fa, m_fb;
    logic [DW-1:0] da [NREQ];
    logic [DW-1:0] db [NREQ];
    logic [NREQ-1:0] cap_ready, deliv;
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NREQ; i++) mcnt[i] = 0;
        mptr = 0; ksr = 0; m_iv = 1'b0; m_err = 1'b0;
        m_fa = '0; m_fb = '0; q.delete(); deliv = '0;
    endtask

    // Called at a negedge; drives one cycle, checks, advances model, ends at next negedge.
    task automatic step(input logic [NREQ-1:0] rv, input logic [NREQ-1:0] cr, input logic inj);
        int g;
        logic [NREQ-1:0] er, ev;
        logic [DW-1:0] ed;
        req_valid = rv; res_credit = cr; inject = inj;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*DW +: DW] = da[i];
            req_b[i*DW +: DW] = db[i];
        end
        #1;
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (mptr + k) % NREQ;
            if (g < 0 && rv[i] && mcnt[i] < MAXOUT) g = i;
        end
        er = '0;
        if (g >= 0) er[g] = 1'b1;
        cap_ready = req_ready;
        chk("req_ready", 64'(req_ready), 64'(er));
        chk("fp_in_valid", 64'(fp_in_valid), 64'(m_iv));
        if (m_iv) begin
            chk("fp_a", 64'(fp_a), 64'(m_fa));
            chk("fp_b", 64'(fp_b), 64'(m_fb));
        end
        ev = '0; ed = '0;
        if (q.size() > 0 && q[0].due == cyc) begin
            ev[q[0].id] = 1'b1;
            ed = q[0].d;
        end
        chk("res_valid", 64'(res_valid), 64'(ev));
        if (ev != '0) chk("res_data", 64'(res_data), 64'(ed));
        if (res_valid != '0) n_res_seen++;
        chk("err", 64'(err), 64'(m_err));
        if (ev != '0) void'(q.pop_front());
        if (g >= 0) begin
            q.push_back('{g, fpadd(da[g], db[g]), cyc + LAT + 2});
            m_iv = 1'b1; m_fa = da[g]; m_fb = db[g];
            mcnt[g]++;
            mptr = (g + 1) % NREQ;
        end else begin
            m_iv = 1'b0;
        end
        for (int i = 0; i < NREQ; i++) begin
            if (cr[i]) begin
                if (mcnt[i] == 0) m_err = 1'b1;
                else mcnt[i]--;
            end
        end
        if (inj && ksr >= LAT + 1) m_err = 1'b1;
        last_grant = g; deliv = ev;
        cyc++; ksr++;
        @(negedge clk);
    endtask

    task automatic do_reset();
        req_valid = '0; res_credit = '0; inject = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_fp_in_valid", 64'(fp_in_valid), 64'd0);
        chk("rst_fp_a", 64'(fp_a), 64'd0);
        chk("rst_fp_b", 64'(fp_b), 64'd0);
        chk("rst_res_valid", 64'(res_valid), 64'd0);
        chk("rst_res_data", 64'(res_data), 64'd0);
        chk("rst_err", 64'(err), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0);
    endtask

    typedef struct { logic [NREQ-1:0] rv; logic [NREQ-1:0] rdy; } vec_t;
    vec_t tbl [10];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int ngr;
        cyc = 0; n_res_seen = 0; last_grant = -1;
        for (int i = 0; i < NREQ; i++) begin da[i] = rnd_fp(); db[i] = rnd_fp(); end
        model_reset();
        repeat (LAT + 3) @(negedge clk);
        do_reset();

        // Arbitration table from reset state (ptr=0, cnt=0).
        tbl[0] = '{4'b0000, 4'b0000}; tbl[1] = '{4'b0001, 4'b0001};
        tbl[2] = '{4'b0001, 4'b0001}; tbl[3] = '{4'b1111, 4'b0010};
        tbl[4] = '{4'b1011, 4'b1000}; tbl[5] = '{4'b0110, 4'b0010};
        tbl[6] = '{4'b0011, 4'b0001}; tbl[7] = '{4'b1100, 4'b0100};
        tbl[8] = '{4'b0000, 4'b0000}; tbl[9] = '{4'b0101, 4'b0001};
        for (int i = 0; i < 10; i++) begin
            step(tbl[i].rv, '0, 1'b0);
            chk("tbl_ready", 64'(cap_ready), 64'(tbl[i].rdy));
        end
        idle(LAT + 4);

        // Single requester, 1.0 + 2.0.
        do_reset();
        da[0] = 32'h3F800000; db[0] = 32'h40000000;
        step(4'b0001, '0, 1'b0);
        chk("single_issue", 64'(fp_in_valid), 64'd1);
        idle(12);
        chk("single_early", 64'(res_valid), 64'd0);
        step('0, '0, 1'b0);
        chk("single_res_valid", 64'(res_valid), 64'b0001);
        chk("single_res_data", 64'(res_data), 64'h40400000);
        chk("single_err", 64'(err), 64'd0);
        idle(3);

        // Fairness with immediate credit return.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin da[i] = rnd_fp(); db[i] = rnd_fp(); end
        for (int k = 0; k < 16; k++) begin
            step(4'b1111, deliv, 1'b0);
            chk("fair_order", 64'(last_grant), 64'(k % NREQ));
        end
        for (int k = 0; k < LAT + 4; k++) step('0, deliv, 1'b0);

        // Credit limit on requester 2.
        do_reset();
        for (int k = 0; k < MAXOUT; k++) begin
            step(4'b0100, '0, 1'b0);
            chk("limit_grant", 64'(last_grant), 64'd2);
        end
        for (int k = 0; k < 3; k++) begin
            step(4'b0100, '0, 1'b0);
            chk("limit_block", 64'(cap_ready), 64'd0);
        end
        step(4'b0100, 4'b0100, 1'b0);
        chk("limit_credit_cycle", 64'(cap_ready), 64'd0);
        step(4'b0100, '0, 1'b0);
        chk("limit_regrant", 64'(cap_ready), 64'b0100);
        step(4'b0100, '0, 1'b0);
        chk("limit_reblock", 64'(cap_ready), 64'd0);
        idle(LAT + 4);

        // Grant and credit together at cnt=5, then credit underflow on requester 3.
        do_reset();
        for (int k = 0; k < 5; k++) step(4'b0010, '0, 1'b0);
        step(4'b0010, 4'b0010, 1'b0);
        chk("gc_grant", 64'(last_grant), 64'd1);
        ngr = 0;
        for (int k = 0; k < 6; k++) begin
            step(4'b0010, '0, 1'b0);
            if (last_grant == 1) ngr++;
        end
        chk("gc_remaining", 64'(ngr), 64'd3);
        step('0, 4'b1000, 1'b0);
        chk("underflow_err", 64'(err), 64'd1);
        idle(LAT + 6);
        chk("err_sticky", 64'(err), 64'd1);

        // Tag mismatch after warm-up.
        do_reset();
        idle(30);
        step('0, '0, 1'b1);
        chk("tag_err", 64'(err), 64'd1);
        chk("tag_no_res", 64'(res_valid), 64'd0);
        idle(2);

        // Same injection inside warm-up is masked.
        do_reset();
        idle(3);
        step('0, '0, 1'b1);
        idle(20);
        chk("warm_mask", 64'(err), 64'd0);

        // Reset with six ops in flight.
        do_reset();
        for (int i = 0; i < NREQ; i++) begin da[i] = rnd_fp(); db[i] = rnd_fp(); end
        for (int k = 0; k < 6; k++) step(4'b1111, '0, 1'b0);
        do_reset();
        n_res_seen = 0;
        idle(LAT + 6);
        chk("midrst_no_res", 64'(n_res_seen), 64'd0);
        chk("midrst_err", 64'(err), 64'd0);

        // Randomized traffic against the reference model.
        do_reset();
        for (int k = 0; k < 400; k++) begin
            logic [NREQ-1:0] rv, cr;
            for (int i = 0; i < NREQ; i++) begin
                da[i] = rnd_fp(); db[i] = rnd_fp();
            end
            rv = NREQ'($urandom);
            cr = '0;
            for (int i = 0; i < NREQ; i++) begin
                if (mcnt[i] > 0 && $urandom_range(0, 2) == 0) cr[i] = 1'b1;
            end
            step(rv, cr, 1'b0);
        end
        idle(LAT + 4);
        chk("rand_queue_empty", 64'(q.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
